// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory arbiter: FSM encoding, port IDs and
// default bus widths.
package mem_arb_pkg;

  localparam int ADDR_WIDTH_DEF = 10;
  localparam int DATA_WIDTH_DEF = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick between instruction fetch and data
// access; a tie goes to whichever port was not served last.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = if_req | dm_req;
    grant_id    = PORT_IF;
    if (if_req && dm_req) begin
      grant_id = ~last_grant;
    end else if (dm_req) begin
      grant_id = PORT_DM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF reads and DM reads/writes onto one single-port memory using a
// three-state (grant, access, respond) FSM with round-robin arbitration.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_ready,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  if_ready_q, if_ready_d;
  logic                  dm_ready_q, dm_ready_d;

  logic arb_valid;
  logic arb_id;

  rr_arbiter2 u_rr_arbiter2 (
    .if_req      (if_req),
    .dm_req      (dm_req),
    .last_grant  (last_grant_q),
    .grant_valid (arb_valid),
    .grant_id    (arb_id)
  );

  // Ready pulses are only ever raised by the ACCESS edge, so they default low
  // and naturally drop at the end of RESP.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_ready_d   = 1'b0;
    dm_ready_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d      = ST_ACCESS;
          grant_d      = arb_id;
          last_grant_d = arb_id;
          if (arb_id == PORT_DM) begin
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            mem_we_d    = dm_we;
          end else begin
            mem_addr_d = if_addr;
            mem_we_d   = 1'b0;
          end
        end
      end
      ST_ACCESS: begin
        state_d  = ST_RESP;
        mem_we_d = 1'b0;
        if (grant_q == PORT_DM) begin
          dm_ready_d = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end else begin
          if_ready_d = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        mem_we_d = 1'b0;
      end
    endcase
  end

  // Async reset clears mem_we at once, so an in-flight write never commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_IF;
      grant_q      <= PORT_IF;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_ready_q   <= 1'b0;
      dm_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_ready_q   <= if_ready_d;
      dm_ready_q   <= dm_ready_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port word-addressed Memory (10-bit Addr, 32-bit data, combinational read, write on rising clk) between two requesters: instruction fetch (IF) and data access (DM).
- Sits between the instruction parser/fetch logic, the load/store path and the Memory instance.
- Serialises accesses with a req/ready handshake and round-robin arbitration, so neither port starves.

Parameters:
- ADDR_WIDTH, 10, word address width; matches Memory Addr.
- DATA_WIDTH, 32, data word width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  IF read request; level, held until if_ready.
- if_addr  in  ADDR_WIDTH  IF word address; stable while if_req is high.
- if_ready  out  1  one-cycle pulse; if_rdata valid in the same cycle.
- if_rdata  out  DATA_WIDTH  registered IF read data.
- dm_req  in  1  DM request; level, held until dm_ready.
- dm_we  in  1  1 = write, 0 = read; stable while dm_req is high.
- dm_addr  in  ADDR_WIDTH  DM word address.
- dm_wdata  in  DATA_WIDTH  DM write data.
- dm_ready  out  1  one-cycle completion pulse for read or write.
- dm_rdata  out  DATA_WIDTH  registered DM read data.
- mem_addr  out  ADDR_WIDTH  to Memory Addr.
- mem_we  out  1  to Memory regWE.
- mem_wdata  out  DATA_WIDTH  to Memory DataIn.
- mem_rdata  in  DATA_WIDTH  from Memory DataOut.

Behaviour:
- Reset (async, rst_n = 0), all registered:
  - state = IDLE, last_grant = IF.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
  - mem_we, if_ready, dm_ready = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both request: grant the port that is not last_grant, so the first tie after reset goes to DM.
  - On grant, at the clock edge: latch mem_addr from the granted address; latch mem_wdata and mem_we (dm_we) for DM; mem_we = 0 for IF. Update last_grant and go to ACCESS.
- ACCESS (exactly 1 cycle):
  - Memory sees mem_addr and mem_we.
  - A write commits at the closing edge.
  - At that edge: a read captures mem_rdata into the granted port's rdata register; mem_we clears to 0; the granted port's ready is set.
  - Next state is RESP.
- RESP (1 cycle):
  - The granted port's ready = 1; ready clears at the closing edge.
  - Next state is IDLE.
  - All requests are ignored in RESP. The requester must drop req in the ready cycle or it is treated as a new request in IDLE.
- Timing:
  - Request seen in IDLE at cycle 0 gives ready in cycle 2.
  - Throughput is one access per 3 cycles.
  - Worst-case wait for a port while the other is continuously busy is 6 cycles (round-robin guarantee).
- DM writes: dm_rdata is not updated and holds its previous value. dm_ready still pulses.
- rdata registers hold their value until the next read on the same port.
- mem_addr holds its last latched value in IDLE and RESP. mem_we is 1 only in ACCESS of a DM write.
- Reset mid-operation:
  - mem_we and the ready outputs drop immediately (asynchronously).
  - An in-flight write is aborted (not committed at any later edge).
  - No ready is issued for the aborted access.
- Requests arriving during ACCESS or RESP wait. Address and data are sampled only at the grant edge.
- All address arithmetic is pass-through. No wrap or offset is applied.

Decomposition:
- Package mem_arb_pkg:
  - state encoding (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2);
  - port IDs PORT_IF = 1'b0, PORT_DM = 1'b1;
  - default ADDR_WIDTH / DATA_WIDTH constants.
- Sub-module rr_arbiter2: a combinational 2-way round-robin pick.
  - Inputs: if_req, dm_req, last_grant.
  - Outputs: grant_valid, grant_id.
- The FSM and the datapath registers stay in mem_port_arbiter.

Test Plan:
- Reset values:
  - Stimulus: hold rst_n = 0 for 2 cycles with both reqs high.
  - Response: all outputs are 0 and no mem_we pulse. After release, DM is granted first (tie, last_grant = IF).
- DM write, then DM read:
  - Stimulus: DM write addr 10'h005 data 32'hDEADBEEF.
  - Response: mem_we = 1 for exactly 1 cycle (cycle 1); dm_ready pulses in cycle 2; dm_rdata is unchanged.
  - Stimulus: DM read of addr 5.
  - Response: dm_rdata = 32'hDEADBEEF with dm_ready.
- IF read:
  - Stimulus: memory preloaded word 3 = 32'h2008000A; if_req with if_addr = 3.
  - Response: if_ready 2 cycles after the request; if_rdata = 32'h2008000A; mem_we stays 0 throughout.
- Contention:
  - Stimulus: both ports hold req continuously.
  - Response: grants alternate DM, IF, DM, IF. Each ready is 3 cycles apart and no port waits more than 6 cycles.
- Held req after ready:
  - Stimulus: IF keeps if_req high through the if_ready cycle.
  - Response: exactly one new access, starting from IDLE; no duplicate ready in RESP.
- Reset mid-write:
  - Stimulus: assert rst_n = 0 in ACCESS of a write of 32'h12345678 to addr 7 (previously 0).
  - Response: mem_we falls immediately; dm_ready is never asserted; a later read of addr 7 returns 0.
